sensor_frame_assembler: RTL and testbench

Sits downstream of the serial sensor receive path. Brings the sensor's serial clock/data (RCLK/RDATA) into the CLK domain and assembles LSB-first bytes into fixed-length frames. Presents each complete frame to the navigation logic through a one-entry VALID/READY output register. An idle-gap timeout recovers bit/byte alignment without an external RESET strobe.

---
 rtl/sensor_frame_if.sv | 22 ++
 rtl/sensor_frame_assembler.sv | 139 +++++++++++++
 tb/tb_sensor_frame_assembler.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_frame_if.sv
// Serial sensor input and frame output handshake bundle for sensor_frame_assembler.
interface sensor_frame_if #(
  parameter int NUM_BYTES = 4
);
  logic                   rclk;
  logic                   rdata;
  logic [8*NUM_BYTES-1:0] frame_data;
  logic                   frame_valid;
  logic                   frame_ready;
  logic                   overrun;
  logic                   resync;

  modport master (
    input  rclk, rdata, frame_ready,
    output frame_data, frame_valid, overrun, resync
  );

  modport slave (
    output rclk, rdata, frame_ready,
    input  frame_data, frame_valid, overrun, resync
  );
endinterface

// File: rtl/sensor_frame_assembler.sv
// Brings the sensor serial link into the clk domain, packs LSB-first bytes into
// fixed-length frames and presents them through a one-entry VALID/READY register.
module sensor_frame_assembler #(
  parameter int NUM_BYTES = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic           clk,
  input  logic           reset,
  sensor_frame_if.master bus
);
  localparam int          FRAME_W    = 8 * NUM_BYTES;
  localparam logic [15:0] TIMEOUT_V  = 16'(TIMEOUT);
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_BYTE  = 3'(NUM_BYTES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [2:0]         rclk_sync_r;
  logic [1:0]         rdata_sync_r;
  logic [2:0]         bit_cnt_r, bit_cnt_s;
  logic [2:0]         byte_cnt_r, byte_cnt_s;
  logic [7:0]         shift_r, shift_s;
  logic [FRAME_W-1:0] asm_r, asm_s;
  logic [15:0]        timer_r, timer_s;
  logic [FRAME_W-1:0] frame_data_r;
  logic               frame_valid_r, overrun_r, resync_r;
  logic               edge_s, bit_s, frame_done_s, timeout_s, load_s, drain_s;

  assign edge_s  = rclk_sync_r[1] & ~rclk_sync_r[2];
  assign bit_s   = rdata_sync_r[1];
  assign drain_s = frame_valid_r & bus.frame_ready;
  assign load_s  = frame_done_s & (~frame_valid_r | bus.frame_ready);

  assign bus.frame_data  = frame_data_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.overrun     = overrun_r;
  assign bus.resync      = resync_r;

  // Synchronizers; rclk gets a third stage for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rclk_sync_r  <= 3'b000;
      rdata_sync_r <= 2'b00;
    end else begin
      rclk_sync_r  <= {rclk_sync_r[1:0], bus.rclk};
      rdata_sync_r <= {rdata_sync_r[0], bus.rdata};
    end
  end

  // Receive FSM next state, bit/byte assembly and idle timer.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    byte_cnt_s   = byte_cnt_r;
    shift_s      = shift_r;
    asm_s        = asm_r;
    timer_s      = timer_r;
    frame_done_s = 1'b0;
    timeout_s    = 1'b0;
    if (edge_s) begin
      // An edge always wins over a coincident timeout.
      timer_s            = 16'd0;
      shift_s[bit_cnt_r] = bit_s;
      bit_cnt_s          = bit_cnt_r + 3'd1;
      state_s            = RECV;
      if (bit_cnt_r == 3'd7) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          asm_s[i*8 +: 8] = (byte_cnt_r == 3'(i)) ? shift_s : asm_r[i*8 +: 8];
        end
        if (byte_cnt_r == LAST_BYTE) begin
          frame_done_s = 1'b1;
          byte_cnt_s   = 3'd0;
          state_s      = IDLE;
        end else begin
          byte_cnt_s = byte_cnt_r + 3'd1;
        end
      end else begin
        byte_cnt_s = byte_cnt_r;
      end
    end else begin
      timer_s = (timer_r == TIMEOUT_V) ? timer_r : timer_r + 16'd1;
      case (state_r)
        RECV: begin
          if (timer_r == TIMEOUT_M1) begin
            timeout_s  = 1'b1;
            bit_cnt_s  = 3'd0;
            byte_cnt_s = 3'd0;
            state_s    = IDLE;
          end else begin
            state_s = RECV;
          end
        end
        IDLE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Receive state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 3'd0;
      shift_r    <= 8'd0;
      asm_r      <= '0;
      timer_r    <= 16'd0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      shift_r    <= shift_s;
      asm_r      <= asm_s;
      timer_r    <= timer_s;
    end
  end

  // One-entry output register; a completed frame is dropped only when the entry stays full.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_data_r  <= '0;
      frame_valid_r <= 1'b0;
      overrun_r     <= 1'b0;
      resync_r      <= 1'b0;
    end else begin
      if (load_s) begin
        frame_data_r  <= asm_s;
        frame_valid_r <= 1'b1;
      end else if (drain_s) begin
        frame_valid_r <= 1'b0;
      end else begin
        frame_valid_r <= frame_valid_r;
      end
      overrun_r <= overrun_r | (frame_done_s & ~load_s);
      resync_r  <= timeout_s;
    end
  end
endmodule

// File: tb/tb_sensor_frame_assembler.sv
// Directed bench for sensor_frame_assembler: frame-level model plus per-cycle compare.
module tb_sensor_frame_assembler;
  localparam int NB  = 4;
  localparam int TO  = 64;
  localparam int FW  = 8 * NB;
  localparam int LAT = 3;  // clk edges from rclk rise until the bit takes effect

  logic clk = 1'b0;
  logic reset;

  sensor_frame_if #(.NUM_BYTES(NB)) bus ();

  sensor_frame_assembler #(.NUM_BYTES(NB), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Frame-level model state
  logic [FW-1:0] m_bits, m_comp_frame, m_data;
  int            m_partial, m_comp_cyc, m_resync_cyc, last_rise;
  logic          m_valid, m_overrun, m_resync, m_drain;
  logic          lenient = 1'b0;

  // Observations from the compare process
  logic [FW-1:0] last_xfer = '0;
  logic [FW-1:0] pd;
  logic          pv, pr;
  int            valid_cycles = 0;
  int            resync_count = 0;
  int            resync_at    = -1;
  int            r0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_clear();
    m_partial    = 0;
    m_comp_cyc   = -1;
    m_resync_cyc = -1;
    m_valid      = 1'b0;
    m_overrun    = 1'b0;
    m_resync     = 1'b0;
    m_data       = '0;
  endtask

  // Model: frames complete LAT edges after their final rclk rise; partial frames expire TO later.
  initial begin
    m_bits = '0;
    m_clear();
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_clear();
      end else begin
        m_drain  = m_valid & bus.frame_ready;
        m_resync = 1'b0;
        if (cyc == m_resync_cyc && m_partial != 0) begin
          m_resync  = 1'b1;
          m_partial = 0;
        end
        if (cyc == m_comp_cyc) begin
          if (!m_valid || m_drain) begin
            m_data  = m_comp_frame;
            m_valid = 1'b1;
          end else begin
            m_overrun = 1'b1;
          end
        end else if (m_drain) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle.
  initial begin
    forever begin
      @(posedge clk);
      pv = bus.frame_valid;
      pr = bus.frame_ready;
      pd = bus.frame_data;
      #1;
      if (pv && pr) last_xfer = pd;
      check("no_x", 64'($isunknown({bus.frame_data, bus.frame_valid, bus.overrun, bus.resync})), 64'd0);
      check("valid", 64'(bus.frame_valid), 64'(m_valid));
      if (m_valid) check("data", 64'(bus.frame_data), 64'(m_data));
      check("overrun", 64'(bus.overrun), 64'(m_overrun));
      if (!lenient) check("resync", 64'(bus.resync), 64'(m_resync));
      if (bus.frame_valid) valid_cycles++;
      if (bus.resync) begin
        resync_count++;
        resync_at = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One rclk period of 8 clk cycles; optionally pulse ready in the frame-completion cycle.
  task automatic send_bit(input logic b, input logic pulse_ready);
    bus.rdata = b;
    idle(2);
    bus.rclk  = 1'b1;
    last_rise = cyc;
    m_bits[m_partial] = b;
    m_partial++;
    m_resync_cyc = cyc + LAT + TO;
    if (m_partial == FW) begin
      m_comp_frame = m_bits;
      m_comp_cyc   = cyc + LAT;
      m_partial    = 0;
    end
    idle(2);
    if (pulse_ready) bus.frame_ready = 1'b1;
    idle(1);
    if (pulse_ready) bus.frame_ready = 1'b0;
    idle(1);
    bus.rclk = 1'b0;
    idle(2);
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input logic pulse_last);
    for (int i = 0; i < FW; i++) send_bit(f[i], pulse_last && (i == FW - 1));
  endtask

  task automatic send_bits(input logic [FW-1:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i], 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.rclk = 1'b0;
    bus.rdata = 1'b0;
    bus.frame_ready = 1'b0;
    idle(3);
    check("rst_data", 64'(bus.frame_data), 64'd0);
    check("rst_valid", 64'(bus.frame_valid), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    check("rst_resync", 64'(bus.resync), 64'd0);
    reset = 1'b0;
    idle(2);

    // Single frame, consumer always ready
    bus.frame_ready = 1'b1;
    valid_cycles = 0;
    send_frame(32'h78563412, 1'b0);
    idle(4);
    check("t1_data", 64'(last_xfer), 64'h78563412);
    check("t1_valid_cycles", 64'(valid_cycles), 64'd1);
    check("t1_overrun", 64'(bus.overrun), 64'd0);

    // Second frame while the first is held: dropped, overrun set
    bus.frame_ready = 1'b0;
    send_frame(32'h78563412, 1'b0);
    send_frame(32'hAABBCCDD, 1'b0);
    idle(2);
    check("t2_data_held", 64'(bus.frame_data), 64'h78563412);
    check("t2_valid", 64'(bus.frame_valid), 64'd1);
    check("t2_overrun", 64'(bus.overrun), 64'd1);
    bus.frame_ready = 1'b1;
    idle(1);
    bus.frame_ready = 1'b0;
    idle(2);
    check("t2_consumed", 64'(last_xfer), 64'h78563412);
    check("t2_valid_after", 64'(bus.frame_valid), 64'd0);

    // Reset in the middle of a frame
    send_bits(32'h000A5A5A, 20);
    reset = 1'b1;
    idle(2);
    check("t5_rst_data", 64'(bus.frame_data), 64'd0);
    check("t5_rst_valid", 64'(bus.frame_valid), 64'd0);
    check("t5_rst_overrun", 64'(bus.overrun), 64'd0);
    check("t5_rst_resync", 64'(bus.resync), 64'd0);
    reset = 1'b0;
    idle(2);
    bus.frame_ready = 1'b1;
    send_frame(32'h44332211, 1'b0);
    idle(4);
    check("t5_frame", 64'(last_xfer), 64'h44332211);
    check("t5_overrun", 64'(bus.overrun), 64'd0);

    // Partial frame of 13 bits expires, then alignment is recovered
    r0 = resync_count;
    send_bits(32'h00000B6D, 13);
    idle(TO + 20);
    check("t3_resync_count", 64'(resync_count - r0), 64'd1);
    check("t3_resync_delay", 64'(resync_at - (last_rise + LAT)), 64'(TO));
    send_frame(32'h04030201, 1'b0);
    idle(4);
    check("t3_frame", 64'(last_xfer), 64'h04030201);

    // Ready rises in the same cycle a new frame completes behind a pending one
    bus.frame_ready = 1'b0;
    send_frame(32'hCAFEF00D, 1'b0);
    send_frame(32'h12345678, 1'b1);
    idle(1);
    check("t4_old_xfer", 64'(last_xfer), 64'hCAFEF00D);
    check("t4_valid", 64'(bus.frame_valid), 64'd1);
    check("t4_new_data", 64'(bus.frame_data), 64'h12345678);
    check("t4_overrun", 64'(bus.overrun), 64'd0);
    bus.frame_ready = 1'b1;
    idle(2);
    check("t4_new_xfer", 64'(last_xfer), 64'h12345678);

    // Narrow rclk pulse: detection optional, timeout must still recover
    lenient = 1'b1;
    r0 = resync_count;
    send_bits(32'h00000005, 3);
    bus.rdata = 1'b1;
    idle(2);
    bus.rclk = 1'b1;
    idle(1);
    bus.rclk = 1'b0;
    idle(TO + 40);
    check("t6_resync_seen", 64'(resync_count - r0 >= 1), 64'd1);
    m_partial = 0;
    lenient = 1'b0;
    send_frame(32'h5AC3E10F, 1'b0);
    idle(4);
    check("t6_frame", 64'(last_xfer), 64'h5AC3E10F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
